// File: rtl/laser_scan_ctrl.sv
// Two-circle placement search: raster-scans candidate centres for one circle
// while the other is fixed, alternating circles until no move or MAX_ITER pairs.
module laser_scan_ctrl #(
  parameter int unsigned MAX_ITER = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       EVAL_REQ,
  output logic [3:0] EVAL_CX,
  output logic [3:0] EVAL_CY,
  output logic       EVAL_SEL,
  input  logic       EVAL_ACK,
  input  logic [5:0] EVAL_CNT,
  output logic [3:0] C1X,
  output logic [3:0] C1Y,
  output logic [3:0] C2X,
  output logic [3:0] C2Y,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned IW = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ENDPASS, FINISH} state_t;

  state_t        state, state_nx;
  logic [3:0]    cand_x, cand_y;
  logic [3:0]    best_x, best_y;
  logic [5:0]    best_cnt;
  logic [IW-1:0] iter;
  logic          sel;
  logic          changed;

  logic          last_cand;
  logic          take;
  logic          changed_eff;
  logic [IW-1:0] iter_inc;
  logic          search_end;
  logic [3:0]    mv_x, mv_y;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    last_cand   = (cand_x == 4'hF) && (cand_y == 4'hF);
    mv_x        = sel ? C2X : C1X;
    mv_y        = sel ? C2Y : C1Y;
    take        = (best_cnt != '0) && ((best_x != mv_x) || (best_y != mv_y));
    // a move made in this very ENDPASS still counts toward the pair's change
    changed_eff = changed | take;
    iter_inc    = iter + 1'b1;
    search_end  = !changed_eff || (iter_inc == IW'(MAX_ITER));

    EVAL_REQ    = (state == WAIT);
    BUSY        = (state != IDLE);
    DONE        = (state == FINISH);

    case (state)
      IDLE:    if (START) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (EVAL_ACK) state_nx = last_cand ? ENDPASS : ISSUE;
      ENDPASS: state_nx = (sel && search_end) ? FINISH : ISSUE;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cand_x   <= '0;
      cand_y   <= '0;
      best_x   <= '0;
      best_y   <= '0;
      best_cnt <= '0;
      iter     <= '0;
      sel      <= 1'b0;
      changed  <= 1'b0;
      C1X      <= '0;
      C1Y      <= '0;
      C2X      <= '0;
      C2Y      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            C1X      <= 4'd4;
            C1Y      <= 4'd4;
            C2X      <= 4'd11;
            C2Y      <= 4'd11;
            sel      <= 1'b0;
            iter     <= '0;
            cand_x   <= '0;
            cand_y   <= '0;
            best_x   <= '0;
            best_y   <= '0;
            best_cnt <= '0;
            changed  <= 1'b0;
          end
        end
        WAIT: begin
          if (EVAL_ACK) begin
            if (EVAL_CNT > best_cnt) begin
              best_cnt <= EVAL_CNT;
              best_x   <= cand_x;
              best_y   <= cand_y;
            end
            if (!last_cand) begin
              cand_x <= cand_x + 1'b1;
              if (cand_x == 4'hF) cand_y <= cand_y + 1'b1;
            end
          end
        end
        ENDPASS: begin
          if (take) begin
            if (sel) begin
              C2X <= best_x;
              C2Y <= best_y;
            end else begin
              C1X <= best_x;
              C1Y <= best_y;
            end
          end
          best_cnt <= '0;
          cand_x   <= '0;
          cand_y   <= '0;
          if (!sel) begin
            sel     <= 1'b1;
            changed <= changed_eff;
          end else begin
            iter <= iter_inc;
            if (search_end) begin
              changed <= changed_eff;
            end else begin
              sel     <= 1'b0;
              changed <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign EVAL_CX  = cand_x;
  assign EVAL_CY  = cand_y;
  assign EVAL_SEL = sel;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Directed bench for laser_scan_ctrl: behavioural point-count responder plus
// hand-computed final centres and busy-cycle counts per scenario.
module tb_laser_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       EVAL_REQ;
  logic [3:0] EVAL_CX, EVAL_CY;
  logic       EVAL_SEL;
  logic       EVAL_ACK = 1'b0;
  logic [5:0] EVAL_CNT = '0;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic       BUSY, DONE;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  bit rand_dly = 1'b0;
  int stable_bad = 0;

  laser_scan_ctrl #(.MAX_ITER(8)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .EVAL_REQ(EVAL_REQ), .EVAL_CX(EVAL_CX), .EVAL_CY(EVAL_CY), .EVAL_SEL(EVAL_SEL),
    .EVAL_ACK(EVAL_ACK), .EVAL_CNT(EVAL_CNT),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 3 targets one step right of the fixed circle, so every pass moves
  function automatic int model_cnt();
    logic [3:0] tx, ty;
    case (mode)
      0: return 0;
      1: return ((!EVAL_SEL && EVAL_CX == 4'd6 && EVAL_CY == 4'd6) ||
                 ( EVAL_SEL && EVAL_CX == 4'd12 && EVAL_CY == 4'd3)) ? 10 : 1;
      2: return 5;
      default: begin
        tx = EVAL_SEL ? C1X + 4'd1 : C2X + 4'd1;
        ty = EVAL_SEL ? C1Y : C2Y;
        return (EVAL_CX == tx && EVAL_CY == ty) ? 10 : 1;
      end
    endcase
  endfunction

  bit         in_req = 1'b0;
  int         wcnt, dly;
  logic [3:0] rx, ry;
  logic       rs;

  always @(negedge CLK) begin
    if (!EVAL_REQ) begin
      EVAL_ACK = 1'b0;
      in_req   = 1'b0;
    end else begin
      if (!in_req) begin
        in_req = 1'b1;
        wcnt   = 0;
        dly    = rand_dly ? int'($urandom_range(0, 5)) : 0;
        rx = EVAL_CX; ry = EVAL_CY; rs = EVAL_SEL;
      end else if (EVAL_CX !== rx || EVAL_CY !== ry || EVAL_SEL !== rs) begin
        stable_bad++;
      end
      if (wcnt == dly) begin
        EVAL_ACK = 1'b1;
        EVAL_CNT = 6'(model_cnt());
      end else begin
        EVAL_ACK = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic run_search(input string tag, input int m, input bit rnd, input bit poke,
                            input int exp_cyc, input int e1x, input int e1y,
                            input int e2x, input int e2y);
    int  cyc;
    bit  done_seen;
    mode = m;
    rand_dly = rnd;
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    chk({tag, "_first_cx"}, EVAL_CX, 0);
    chk({tag, "_first_cy"}, EVAL_CY, 0);
    chk({tag, "_first_sel"}, EVAL_SEL, 0);
    chk({tag, "_busy"}, BUSY, 1);
    cyc = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 20000 && !done_seen; i++) begin
      if (i > 0) @(negedge CLK);
      if (BUSY) cyc++;
      if (DONE) begin
        done_seen = 1'b1;
        START = poke;
      end else begin
        START = poke && (i % 300 == 7);
      end
    end
    chk({tag, "_done_seen"}, done_seen, 1);
    if (!rnd) chk({tag, "_busy_cycles"}, cyc, exp_cyc);
    chk({tag, "_c1x"}, C1X, e1x);
    chk({tag, "_c1y"}, C1Y, e1y);
    chk({tag, "_c2x"}, C2X, e2x);
    chk({tag, "_c2y"}, C2Y, e2y);
    @(negedge CLK) START = 1'b0;
    chk({tag, "_done_pulse"}, DONE, 0);
    chk({tag, "_idle"}, BUSY, 0);
    repeat (3) @(negedge CLK);
    chk({tag, "_still_idle"}, BUSY, 0);
    chk({tag, "_hold_c1x"}, C1X, e1x);
    chk({tag, "_hold_c2y"}, C2Y, e2y);
  endtask

  initial begin
    bit got_req;
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_req", EVAL_REQ, 0);
    chk("rst_done", DONE, 0);
    chk("rst_c1x", C1X, 0);
    chk("rst_c2y", C2Y, 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("no_start_busy", BUSY, 0);

    run_search("zero",  0, 1'b0, 1'b0, 1027, 4, 4, 11, 11);
    run_search("peak",  1, 1'b0, 1'b0, 2053, 6, 6, 12, 3);
    run_search("tie",   2, 1'b0, 1'b0, 2053, 0, 0, 0, 0);
    run_search("alt",   3, 1'b0, 1'b0, 8209, 10, 11, 11, 11);
    run_search("rnd",   1, 1'b1, 1'b1, 0, 6, 6, 12, 3);

    // abort mid-handshake with an asynchronous reset
    mode = 0;
    rand_dly = 1'b0;
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    repeat (40) @(negedge CLK);
    got_req = 1'b0;
    for (int i = 0; i < 10 && !got_req; i++) begin
      if (EVAL_REQ) got_req = 1'b1;
      else @(negedge CLK);
    end
    chk("abort_req_pre", got_req, 1);
    #1 RST = 1'b1;
    #1;
    chk("abort_req", EVAL_REQ, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_cx", EVAL_CX, 0);
    chk("abort_cy", EVAL_CY, 0);
    chk("abort_sel", EVAL_SEL, 0);
    chk("abort_c1x", C1X, 0);
    chk("abort_c2x", C2X, 0);
    @(negedge CLK) RST = 1'b0;
    repeat (6) @(negedge CLK);
    chk("abort_no_restart", BUSY, 0);
    chk("abort_no_req", EVAL_REQ, 0);
    run_search("restart", 0, 1'b0, 1'b0, 1027, 4, 4, 11, 11);

    chk("req_stable", stable_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
